// File: rtl/config_master_if.sv
// Bundle of host command, outgoing flit, incoming flit and read-result signals for config_master.
// master: the config_master side; slave: the host/NoC side.
interface config_master_if #(
    parameter int unsigned FW  = 59,
    parameter int unsigned XW  = 4,
    parameter int unsigned YW  = 4,
    parameter int unsigned CAW = 15,
    parameter int unsigned CDW = 21
);
    logic           cmd_valid;
    logic           cmd_ready;
    logic           cmd_rw;
    logic [XW-1:0]  cmd_x;
    logic [YW-1:0]  cmd_y;
    logic [CAW-1:0] cmd_addr;
    logic [CDW-1:0] cmd_data;
    logic           flit_out_we;
    logic [FW-1:0]  flit_out_wdata;
    logic           noc_credit;
    logic           resp_we;
    logic [FW-1:0]  resp_wdata;
    logic           resp_credit;
    logic           rsp_valid;
    logic           rsp_err;
    logic [CDW-1:0] rsp_data;
    logic           busy;

    modport master (
        input  cmd_valid, cmd_rw, cmd_x, cmd_y, cmd_addr, cmd_data, noc_credit, resp_we,
               resp_wdata,
        output cmd_ready, flit_out_we, flit_out_wdata, resp_credit, rsp_valid, rsp_err,
               rsp_data, busy
    );

    modport slave (
        output cmd_valid, cmd_rw, cmd_x, cmd_y, cmd_addr, cmd_data, noc_credit, resp_we,
               resp_wdata,
        input  cmd_ready, flit_out_we, flit_out_wdata, resp_credit, rsp_valid, rsp_err,
               rsp_data, busy
    );
endinterface

// File: rtl/config_master.sv
// Host-side config-flit initiator: credit-limited write/read issue and single outstanding read.
// Optional read timeout is built when CONFIG_MASTER_TIMEOUT_EN is defined.
module config_master #(
    parameter int unsigned FW         = 59,
    parameter int unsigned XW         = 4,
    parameter int unsigned YW         = 4,
    parameter int unsigned CAW        = 15,
    parameter int unsigned CDW        = 21,
    parameter int unsigned SRC_X      = 0,
    parameter int unsigned SRC_Y      = 0,
    parameter int unsigned CREDIT_NUM = 4,
    parameter int unsigned TO_CYCLES  = 1024
) (
    input  logic            clk,
    input  logic            rst_n,
    config_master_if.master bus
);
    localparam int unsigned CW      = 4;
    localparam int unsigned ResLsb  = CDW + CAW;
    localparam int unsigned SyLsb   = ResLsb + 4;
    localparam int unsigned SxLsb   = SyLsb + YW;
    localparam int unsigned DyLsb   = SxLsb + XW;
    localparam int unsigned DxLsb   = DyLsb + YW;
    localparam int unsigned TypeLsb = DxLsb + XW;

    localparam logic [2:0]    FtWrite = 3'b100;
    localparam logic [2:0]    FtRead  = 3'b101;
    localparam logic [2:0]    FtResp  = 3'b110;
    localparam logic [XW-1:0] SrcX    = XW'(SRC_X);
    localparam logic [YW-1:0] SrcY    = YW'(SRC_Y);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  credit_q, credit_d;
    logic           flit_we_q, flit_we_d;
    logic [FW-1:0]  flit_q, flit_d;
    logic [XW-1:0]  lat_x_q, lat_x_d;
    logic [YW-1:0]  lat_y_q, lat_y_d;
    logic [CAW-1:0] lat_addr_q, lat_addr_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [CDW-1:0] rsp_data_q, rsp_data_d;
    logic           resp_credit_q;
    logic           cmd_ready_c;
    logic           resp_match;
    logic           unused_rsvd;

`ifdef CONFIG_MASTER_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TO_CYCLES);
    logic [TW-1:0] timer_q, timer_d;
    logic          rsp_err_q, rsp_err_d;

    assign unused_rsvd = ^bus.resp_wdata[ResLsb +: 4];
`else
    assign unused_rsvd = ^{bus.resp_wdata[ResLsb +: 4], TO_CYCLES[0]};
`endif

    assign resp_match = bus.resp_we
                     && (bus.resp_wdata[TypeLsb +: 3] == FtResp)
                     && (bus.resp_wdata[DxLsb +: XW] == SrcX)
                     && (bus.resp_wdata[DyLsb +: YW] == SrcY)
                     && (bus.resp_wdata[SxLsb +: XW] == lat_x_q)
                     && (bus.resp_wdata[SyLsb +: YW] == lat_y_q)
                     && (bus.resp_wdata[CDW +: CAW] == lat_addr_q);

    // Credit count: the registered flit strobe spends one, a noc_credit pulse returns one.
    always_comb begin
        credit_d = credit_q;
        if (flit_we_q && !bus.noc_credit) begin
            credit_d = credit_q - CW'(1);
        end else if (!flit_we_q && bus.noc_credit && (credit_q < CW'(CREDIT_NUM))) begin
            credit_d = credit_q + CW'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        flit_we_d   = 1'b0;
        flit_d      = flit_q;
        lat_x_d     = lat_x_q;
        lat_y_d     = lat_y_q;
        lat_addr_d  = lat_addr_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        cmd_ready_c = 1'b0;
`ifdef CONFIG_MASTER_TIMEOUT_EN
        timer_d     = timer_q;
        rsp_err_d   = rsp_err_q;
`endif
        case (state_q)
            StIdle: begin
                // A flit still on the wire holds a credit not yet deducted from credit_q.
                cmd_ready_c = rst_n && (credit_q > CW'(flit_we_q));
                if (bus.cmd_valid && cmd_ready_c) begin
                    flit_we_d = 1'b1;
                    flit_d    = {bus.cmd_rw ? FtWrite : FtRead, bus.cmd_x, bus.cmd_y, SrcX, SrcY,
                                 4'b0000, bus.cmd_addr, bus.cmd_rw ? bus.cmd_data : {CDW{1'b0}}};
                    if (!bus.cmd_rw) begin
                        lat_x_d    = bus.cmd_x;
                        lat_y_d    = bus.cmd_y;
                        lat_addr_d = bus.cmd_addr;
                        state_d    = StWait;
`ifdef CONFIG_MASTER_TIMEOUT_EN
                        timer_d    = '0;
`endif
                    end
                end
            end
            StWait: begin
                if (resp_match) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = bus.resp_wdata[CDW-1:0];
                    state_d     = StIdle;
`ifdef CONFIG_MASTER_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
                end else if (timer_q == TW'(TO_CYCLES - 1)) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = StIdle;
                end else begin
                    timer_d     = timer_q + TW'(1);
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            credit_q      <= CW'(CREDIT_NUM);
            flit_we_q     <= 1'b0;
            flit_q        <= '0;
            lat_x_q       <= '0;
            lat_y_q       <= '0;
            lat_addr_q    <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            resp_credit_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            flit_we_q     <= flit_we_d;
            flit_q        <= flit_d;
            lat_x_q       <= lat_x_d;
            lat_y_q       <= lat_y_d;
            lat_addr_q    <= lat_addr_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            resp_credit_q <= bus.resp_we;
        end
    end

`ifdef CONFIG_MASTER_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q   <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            timer_q   <= timer_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign bus.rsp_err = rsp_err_q;
`else
    assign bus.rsp_err = 1'b0;
`endif

    assign bus.cmd_ready      = cmd_ready_c;
    assign bus.flit_out_we    = flit_we_q;
    assign bus.flit_out_wdata = flit_q;
    assign bus.resp_credit    = resp_credit_q;
    assign bus.rsp_valid      = rsp_valid_q;
    assign bus.rsp_data       = rsp_data_q;
    assign bus.busy           = (state_q == StWait);
endmodule
